// File: rtl/fpu_pkg.sv
// Shared bfloat16 constants, field widths and the stream accumulator state type.
package fpu_pkg;

   localparam int unsigned BF16_EXP_W = 8;
   localparam int unsigned BF16_MAN_W = 7;

   localparam logic [15:0] BF16_QNAN  = 16'h7FC0;
   localparam logic [15:0] BF16_PINF  = 16'h7F80;
   localparam logic [15:0] BF16_NINF  = 16'hFF80;
   localparam logic [15:0] BF16_PZERO = 16'h0000;

   typedef enum logic {
      S_ACC,
      S_OUT
   } accum_state_e;

endpackage

// File: rtl/Add_Sub.sv
// Combinational bfloat16 adder/subtractor (inst=1 add, inst=0 subtract), round to nearest even.
// Subnormal inputs and results are flushed to zero; NaN results are canonical.
module Add_Sub
   import fpu_pkg::*;
(
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        inst,
   output logic [15:0] C
);

   logic              sa, sb, sl, ss, swap, sticky, rup;
   logic [7:0]        ea, eb, el, es, d;
   logic [6:0]        fa, fb;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [10:0]       ml, ms_ext, ms_al, norm;
   logic [11:0]       sum;
   logic signed [9:0] exp_n;
   logic [8:0]        mant_r;
   logic [3:0]        lz;

   always_comb begin
      sa = A[15];
      ea = A[14:7];
      fa = A[6:0];
      sb = B[15] ^ ~inst;
      eb = B[14:7];
      fb = B[6:0];

      a_nan  = (ea == 8'hFF) && (fa != 7'h0);
      b_nan  = (eb == 8'hFF) && (fb != 7'h0);
      a_inf  = (ea == 8'hFF) && (fa == 7'h0);
      b_inf  = (eb == 8'hFF) && (fb == 7'h0);
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);

      swap   = {eb, fb} > {ea, fa};
      sl     = swap ? sb : sa;
      ss     = swap ? sa : sb;
      el     = swap ? eb : ea;
      es     = swap ? ea : eb;
      ml     = {1'b1, (swap ? fb : fa), 3'b000};
      ms_ext = {1'b1, (swap ? fa : fb), 3'b000};
      d      = el - es;

      // Bits shifted out of the smaller operand collapse into a sticky LSB.
      if (d >= 8'd11) begin
         ms_al  = 11'h0;
         sticky = 1'b1;
      end else begin
         ms_al  = ms_ext >> d;
         sticky = |(ms_ext & ((11'd1 << d) - 11'd1));
      end
      ms_al = ms_al | {10'h0, sticky};

      sum = (sl == ss) ? ({1'b0, ml} + {1'b0, ms_al}) : ({1'b0, ml} - {1'b0, ms_al});

      exp_n = $signed({2'b00, el});
      lz    = 4'd11;
      norm  = sum[10:0];
      if (sum[11]) begin
         norm  = sum[11:1] | {10'h0, sum[0]};
         exp_n = exp_n + 10'sd1;
      end else begin
         for (int i = 0; i <= 10; i++) begin
            if (sum[i]) lz = 4'(10 - i);
         end
         norm  = sum[10:0] << lz;
         exp_n = exp_n - $signed({6'h0, lz});
      end

      rup    = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r = {1'b0, norm[10:3]} + {8'h0, rup};
      if (mant_r[8]) begin
         mant_r = mant_r >> 1;
         exp_n  = exp_n + 10'sd1;
      end

      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
         C = BF16_QNAN;
      end else if (a_inf) begin
         C = sa ? BF16_NINF : BF16_PINF;
      end else if (b_inf) begin
         C = sb ? BF16_NINF : BF16_PINF;
      end else if (a_zero && b_zero) begin
         C = {sa & sb, 15'h0};
      end else if (a_zero) begin
         C = {sb, eb, fb};
      end else if (b_zero) begin
         C = A;
      end else if (sum == 12'h0) begin
         C = BF16_PZERO;
      end else if (exp_n >= 10'sd255) begin
         C = sl ? BF16_NINF : BF16_PINF;
      end else if (exp_n <= 10'sd0) begin
         C = {sl, 15'h0};
      end else begin
         C = {sl, exp_n[7:0], mant_r[6:0]};
      end
   end

endmodule

// File: rtl/Class.sv
// bfloat16 classifier: flags NaN and infinity encodings.
module Class
   import fpu_pkg::*;
(
   input  logic [15:0] A,
   output logic        nan,
   output logic        inf
);

   logic exp_all_ones;
   logic man_zero;

   always_comb begin
      exp_all_ones = (A[14:BF16_MAN_W] == {BF16_EXP_W{1'b1}});
      man_zero     = (A[BF16_MAN_W-1:0] == '0);
      nan          = exp_all_ones & ~man_zero;
      inf          = exp_all_ones & man_zero;
   end

endmodule

// File: rtl/bf16_stream_accum.sv
// Folds a valid/ready stream of bf16 operands into a running sum through Add_Sub and
// presents sum, beat count and class flags on a valid/ready result port.
module bf16_stream_accum
   import fpu_pkg::*;
#(
   parameter int unsigned MAX_BEATS = 256,
   parameter int unsigned CNT_W     = 9
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [15:0]      in_data_i,
   input  logic             in_neg_i,
   input  logic             in_last_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [15:0]      out_data_o,
   output logic [CNT_W-1:0] out_count_o,
   output logic             out_nan_o,
   output logic             out_inf_o,
   output logic             out_trunc_o
);

   accum_state_e     state_q, state_d;
   logic [15:0]      acc_q, acc_d, sum;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             trunc_q, trunc_d;
   logic             accept, last_beat, acc_nan, acc_inf;

   Add_Sub u_add_sub (
      .A    (acc_q),
      .B    (in_data_i),
      .inst (~in_neg_i),
      .C    (sum)
   );

   Class u_class (
      .A   (acc_q),
      .nan (acc_nan),
      .inf (acc_inf)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_ACC;
         acc_q   <= BF16_PZERO;
         cnt_q   <= '0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         trunc_q <= trunc_d;
      end
   end

   always_comb begin
      accept    = in_valid_i & (state_q == S_ACC);
      last_beat = in_last_i | (cnt_q == CNT_W'(MAX_BEATS - 1));
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      trunc_d   = trunc_q;
      unique case (state_q)
         S_ACC: begin
            if (accept) begin
               acc_d = sum;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_beat) begin
                  state_d = S_OUT;
                  trunc_d = ~in_last_i;
               end
            end
         end
         S_OUT: begin
            if (out_ready_i) begin
               state_d = S_ACC;
               acc_d   = BF16_PZERO;
               cnt_d   = '0;
               trunc_d = 1'b0;
            end
         end
         default: state_d = S_ACC;
      endcase
   end

   always_comb begin
      in_ready_o  = (state_q == S_ACC);
      out_valid_o = (state_q == S_OUT);
      out_data_o  = out_valid_o ? acc_q : 16'h0000;
      out_count_o = out_valid_o ? cnt_q : '0;
      out_nan_o   = out_valid_o & acc_nan;
      out_inf_o   = out_valid_o & acc_inf;
      out_trunc_o = out_valid_o & trunc_q;
   end

endmodule
